// File: rtl/controle_multiciclo_pkg.sv
// Shared types and constants for the multicycle RV64I-subset control unit.
package controle_pkg;

    typedef enum logic [3:0] {
        FETCH0   = 4'd0,
        FETCH1   = 4'd1,
        DECODE   = 4'd2,
        R_EXEC   = 4'd3,
        I_EXEC   = 4'd4,
        LUI_EXEC = 4'd5,
        WB_ULA   = 4'd6,
        LD_ADDR  = 4'd7,
        LD_MEM   = 4'd8,
        LD_WAIT  = 4'd9,
        LD_WB    = 4'd10,
        SD_ADDR  = 4'd11,
        SD_MEM   = 4'd12,
        BR       = 4'd13,
        INC      = 4'd14,
        HALT     = 4'd15
    } estado_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_DOUBLE  = 3'b011;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [2:0] ULA_NOP = 3'b000;
    localparam logic [2:0] ULA_ADD = 3'b001;
    localparam logic [2:0] ULA_SUB = 3'b010;
    localparam logic [2:0] ULA_AND = 3'b011;
    localparam logic [2:0] ULA_CMP = 3'b111;

    localparam logic [2:0] MUXA_PC   = 3'd0;
    localparam logic [2:0] MUXA_REGA = 3'd1;
    localparam logic [2:0] MUXA_ZERO = 3'd2;

    localparam logic [2:0] MUXB_REGB   = 3'd0;
    localparam logic [2:0] MUXB_QUATRO = 3'd1;
    localparam logic [2:0] MUXB_IMM    = 3'd2;
    localparam logic [2:0] MUXB_IMM_SH = 3'd3;

    localparam logic [2:0] WB_ULAOUT = 3'd0;
    localparam logic [2:0] WB_MDR    = 3'd1;

endpackage

// File: rtl/controle_multiciclo_decod_ula.sv
// R-type ALU decode: funct3/funct7_5 to ULA operation, flagging unsupported funct3.
module decod_ula
    import controle_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [2:0] Seletor_Ula,
    output logic       ilegal
);

    always_comb begin
        Seletor_Ula = ULA_NOP;
        ilegal      = 1'b0;
        case (funct3)
            F3_ADD_SUB: Seletor_Ula = funct7_5 ? ULA_SUB : ULA_ADD;
            F3_AND:     Seletor_Ula = ULA_AND;
            default:    ilegal      = 1'b1;
        endcase
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Moore multicycle control FSM: decodes the instruction fields and drives
// every datapath enable and mux select from the current state.
module controle_multiciclo
    import controle_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] Op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       igual,
    output logic       PC_Write,
    output logic       PC_src,
    output logic [2:0] Seletor_Ula,
    output logic [2:0] mux_A_seletor,
    output logic [2:0] mux_B_seletor,
    output logic       register_Inst_wr,
    output logic       Data_Memory_wr,
    output logic       bancoRegisters_wr,
    output logic [2:0] Mux_Banco_Reg_Seletor,
    output logic       halt,
    output logic [3:0] estado
);

    localparam estado_t DESTINO_ILEGAL = HALT_ON_ILLEGAL ? HALT : INC;

    estado_t    estado_q;
    estado_t    proximo;
    logic [2:0] ula_r;
    logic       ula_r_ilegal;
    logic       desvio;

    decod_ula u_decod_ula (
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .Seletor_Ula (ula_r),
        .ilegal      (ula_r_ilegal)
    );

    assign desvio = ((funct3 == F3_BEQ) && igual) || ((funct3 == F3_BNE) && !igual);

    always_ff @(posedge clock) begin
        if (reset) estado_q <= FETCH0;
        else       estado_q <= proximo;
    end

    always_comb begin
        proximo               = estado_q;
        PC_Write              = 1'b0;
        PC_src                = 1'b0;
        Seletor_Ula           = ULA_NOP;
        mux_A_seletor         = MUXA_PC;
        mux_B_seletor         = MUXB_REGB;
        register_Inst_wr      = 1'b0;
        Data_Memory_wr        = 1'b0;
        bancoRegisters_wr     = 1'b0;
        Mux_Banco_Reg_Seletor = WB_ULAOUT;
        halt                  = 1'b0;
        case (estado_q)
            FETCH0: proximo = FETCH1;
            FETCH1: begin
                register_Inst_wr = 1'b1;
                proximo          = DECODE;
            end
            // Branch target is precomputed here so BR can load PC from ULAOut.
            DECODE: begin
                Seletor_Ula   = ULA_ADD;
                mux_A_seletor = MUXA_PC;
                mux_B_seletor = MUXB_IMM_SH;
                case (Op)
                    OP_R:    proximo = R_EXEC;
                    OP_I:    proximo = (funct3 == F3_ADDI) ? I_EXEC : DESTINO_ILEGAL;
                    OP_LUI:  proximo = LUI_EXEC;
                    OP_LD:   proximo = (funct3 == F3_DOUBLE) ? LD_ADDR : DESTINO_ILEGAL;
                    OP_SD:   proximo = (funct3 == F3_DOUBLE) ? SD_ADDR : DESTINO_ILEGAL;
                    OP_BR:   proximo = (funct3 == F3_BEQ || funct3 == F3_BNE) ? BR : DESTINO_ILEGAL;
                    default: proximo = DESTINO_ILEGAL;
                endcase
            end
            R_EXEC: begin
                Seletor_Ula   = ula_r;
                mux_A_seletor = MUXA_REGA;
                mux_B_seletor = MUXB_REGB;
                proximo       = ula_r_ilegal ? DESTINO_ILEGAL : WB_ULA;
            end
            I_EXEC: begin
                Seletor_Ula   = ULA_ADD;
                mux_A_seletor = MUXA_REGA;
                mux_B_seletor = MUXB_IMM;
                proximo       = WB_ULA;
            end
            LUI_EXEC: begin
                Seletor_Ula   = ULA_ADD;
                mux_A_seletor = MUXA_ZERO;
                mux_B_seletor = MUXB_IMM;
                proximo       = WB_ULA;
            end
            WB_ULA: begin
                bancoRegisters_wr = 1'b1;
                proximo           = INC;
            end
            // Address held across the memory cycles so ULAOut never moves.
            LD_ADDR, LD_MEM, LD_WAIT: begin
                Seletor_Ula   = ULA_ADD;
                mux_A_seletor = MUXA_REGA;
                mux_B_seletor = MUXB_IMM;
                proximo       = (estado_q == LD_ADDR) ? LD_MEM :
                                (estado_q == LD_MEM)  ? LD_WAIT : LD_WB;
            end
            LD_WB: begin
                bancoRegisters_wr     = 1'b1;
                Mux_Banco_Reg_Seletor = WB_MDR;
                proximo               = INC;
            end
            SD_ADDR, SD_MEM: begin
                Seletor_Ula    = ULA_ADD;
                mux_A_seletor  = MUXA_REGA;
                mux_B_seletor  = MUXB_IMM;
                Data_Memory_wr = (estado_q == SD_MEM);
                proximo        = (estado_q == SD_ADDR) ? SD_MEM : INC;
            end
            BR: begin
                Seletor_Ula   = ULA_CMP;
                mux_A_seletor = MUXA_REGA;
                mux_B_seletor = MUXB_REGB;
                PC_Write      = desvio;
                PC_src        = desvio;
                proximo       = desvio ? FETCH0 : INC;
            end
            INC: begin
                Seletor_Ula   = ULA_ADD;
                mux_A_seletor = MUXA_PC;
                mux_B_seletor = MUXB_QUATRO;
                PC_Write      = 1'b1;
                proximo       = FETCH0;
            end
            HALT: begin
                halt    = 1'b1;
                proximo = HALT;
            end
            default: proximo = FETCH0;
        endcase
        // Reset blanks every output in the cycle it is asserted, aborting any write.
        if (reset) begin
            PC_Write              = 1'b0;
            PC_src                = 1'b0;
            Seletor_Ula           = '0;
            mux_A_seletor         = '0;
            mux_B_seletor         = '0;
            register_Inst_wr      = 1'b0;
            Data_Memory_wr        = 1'b0;
            bancoRegisters_wr     = 1'b0;
            Mux_Banco_Reg_Seletor = '0;
            halt                  = 1'b0;
        end
    end

    assign estado = reset ? 4'd0 : estado_q;

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
Multicycle control unit (Moore FSM) for the RV64I-subset datapath. Decodes the opcode and funct fields from the instruction register and drives all datapath write enables and mux selects each cycle. Supports add/sub/and, addi, lui, ld, sd, beq and bne. Sits directly upstream of the datapath and consumes only the ULA `igual` flag from it.

Parameters:
HALT_ON_ILLEGAL, 1, 1: an unsupported opcode or funct goes to HALT; 0: it is treated as a NOP and goes to INC.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
Op  in  7  instruction bits [6:0]
funct3  in  3  instruction bits [14:12]
funct7_5  in  1  instruction bit [30]
igual  in  1  ULA equality flag
PC_Write  out  1  PC load enable
PC_src  out  1  PC input select: 0 = ULA S, 1 = ULAOut register
Seletor_Ula  out  3  ULA operation
mux_A_seletor  out  3  ULA A input: 0 = PC, 1 = RegA, 2 = zero
mux_B_seletor  out  3  ULA B input: 0 = RegB, 1 = 4, 2 = imm, 3 = imm<<1
register_Inst_wr  out  1  instruction register load
Data_Memory_wr  out  1  data memory write
bancoRegisters_wr  out  1  register file write
Mux_Banco_Reg_Seletor  out  3  register file write data: 0 = ULAOut, 1 = memory data register
halt  out  1  FSM is in HALT
estado  out  4  current state encoding (debug)

Behaviour:
- One clock; reset is synchronous and active-high. While `reset` is high, the state goes to FETCH0 at the clock edge and all outputs are 0.
- Outputs are combinational decodes of the state register. Exceptions: Seletor_Ula in R_EXEC depends on funct3 and funct7_5; PC_Write in BR depends on igual and funct3.
- Unlisted outputs are 0 in every state.
- ULA codes: ADD = 001, SUB = 010, AND = 011, CMP = 111.
- State encodings 0..15: FETCH0, FETCH1, DECODE, R_EXEC, I_EXEC, LUI_EXEC, WB_ULA, LD_ADDR, LD_MEM, LD_WAIT, LD_WB, SD_ADDR, SD_MEM, BR, INC, HALT.
- FETCH0: instruction memory read latency; no enables. Next state FETCH1.
- FETCH1: register_Inst_wr = 1. Next state DECODE.
- DECODE: A = PC, B = imm<<1, ADD; the branch target lands in ULAOut. Next state by Op:
  - 0110011 → R_EXEC
  - 0010011 (funct3 = 000) → I_EXEC
  - 0110111 → LUI_EXEC
  - 0000011 (funct3 = 011) → LD_ADDR
  - 0100011 (funct3 = 011) → SD_ADDR
  - 1100011 (funct3 = 000 or 001) → BR
  - anything else → illegal path (see parameter).
- R_EXEC: A = RegA, B = RegB. funct3 = 000 gives ADD, or SUB if funct7_5 = 1; funct3 = 111 gives AND; any other funct3 is illegal. Next state WB_ULA.
- I_EXEC: RegA + imm → WB_ULA.
- LUI_EXEC: zero + imm → WB_ULA.
- WB_ULA: bancoRegisters_wr = 1, Mux_Banco_Reg_Seletor = 0. Next state INC.
- LD_ADDR, LD_MEM, LD_WAIT: all hold A = RegA, B = imm, ADD so ULAOut stays stable as the memory address. LD_WB: bancoRegisters_wr = 1, Mux_Banco_Reg_Seletor = 1. Next state INC.
- SD_ADDR: RegA + imm. SD_MEM: same ALU selects, Data_Memory_wr = 1 for exactly one cycle. Next state INC.
- BR: A = RegA, B = RegB, CMP. Branch is taken when (funct3 = 000 and igual) or (funct3 = 001 and !igual).
  - Taken: PC_Write = 1, PC_src = 1, next state FETCH0.
  - Not taken: next state INC.
- INC: A = PC, B = 4, ADD, PC_Write = 1, PC_src = 0. Next state FETCH0.
- HALT: all outputs 0, halt = 1, no exit except reset.
- Latencies in cycles: R/addi/lui 6, sd 6, ld 8, branch taken 4, branch not taken 5.
- Reset mid-instruction aborts it: no write enable is asserted in the reset cycle or in the following FETCH0.

Decomposition:
- Package `controle_pkg`: the state enum (4-bit, encodings above); opcode constants OP_R, OP_I, OP_LUI, OP_LD, OP_SD, OP_BR; ULA code constants; mux select constants.
- Sub-module `decod_ula` (combinational: funct3 and funct7_5 → Seletor_Ula plus an illegal flag) is natural. Everything else stays in one module.

Test Plan:
- reset held 3 cycles, then released with Op = 0110011, funct3 = 000, funct7_5 = 0 → estado sequence 0, 1, 2, 3, 6, 14, 0. Seletor_Ula = 001 in R_EXEC; bancoRegisters_wr = 1 only in WB_ULA; PC_Write = 1 only in INC.
- Op = 0110011, funct3 = 000, funct7_5 = 1 → Seletor_Ula = 010 in R_EXEC. funct3 = 111 → Seletor_Ula = 011. funct3 = 100 → HALT with halt = 1.
- ld (Op = 0000011, funct3 = 011) → 8-cycle path. mux_B_seletor = 2 in LD_ADDR, LD_MEM and LD_WAIT; Mux_Banco_Reg_Seletor = 1 with bancoRegisters_wr = 1 in LD_WB only.
- sd (Op = 0100011) → Data_Memory_wr high for exactly one cycle (SD_MEM); bancoRegisters_wr is never asserted.
- beq with igual = 1 → BR asserts PC_Write = 1, PC_src = 1, then FETCH0 (4 cycles). bne with igual = 1 → BR with PC_Write = 0, then INC.
- Illegal opcode 1111111 with HALT_ON_ILLEGAL = 0 → DECODE goes to INC, PC advances, no register or memory write. Reset asserted during LD_MEM → FETCH0 next cycle with all enables 0.
